dsp_decode: RTL
===============

Name: dsp_decode

Overview:
- Decode stage directly downstream of the DSP fetch stage.
- Consumes the fetched instruction word and its address.
- Resolves control flow in the same cycle (JMP, BRZ, hardware zero-overhead LOOP) and drives jump_addr/jump_flag back to fetch.
- Registers decoded fields for the execute stage.

Parameters:
INST_W, 32, instruction word width
ADDR_W, 16, program address width (matches fetch PC)
CNT_W, 10, loop iteration counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
instruction_in  input  INST_W  instruction word from fetch
pc_in  input  ADDR_W  address of instruction_in
zero_flag  input  1  zero flag from execute, used by BRZ
jump_addr  output  ADDR_W  branch/loop-back target to fetch
jump_flag  output  1  redirect fetch at next clk edge
op_out  output  6  registered opcode
rd_out  output  4  registered destination register
rs_out  output  4  registered source register
imm_out  output  16  registered immediate
valid_out  output  1  decoded fields valid
loop_active  output  1  hardware loop in progress
loop_err  output  1  sticky illegal-LOOP flag

Behaviour:
- Reset is asynchronous, active-high. While rst is high, all registered outputs are 0, the loop FSM is IDLE, and jump_flag is forced to 0.
- Instruction format:
  - [31:26] op, [25:22] rd, [21:18] rs, [15:0] imm.
  - For LOOP only: [25:16] is the count N and [15:0] is the end address.
- Opcodes:
  - NOP = 0x00.
  - JMP = 0x30: jump to imm.
  - BRZ = 0x31: jump to imm if zero_flag = 1.
  - LOOP = 0x32.
  - All other opcodes pass through to execute undecoded.
- jump_flag and jump_addr are combinational from instruction_in, pc_in, zero_flag and loop state. Fetch samples them at the same edge, so a redirect costs no bubble.
- Decoded fields have 1-cycle latency. op/rd/rs/imm register instruction_in every cycle; valid_out is 1 every cycle after reset deasserts.
- Loop FSM, states IDLE and ACTIVE:
  - IDLE + LOOP with end ≥ pc_in+1: capture start = pc_in+1, end = imm, cnt = max(N,1). Enter ACTIVE next cycle.
  - ACTIVE, pc_in == end, cnt > 1: jump_flag = 1, jump_addr = start, cnt decrements.
  - ACTIVE, pc_in == end, cnt == 1: no jump, return to IDLE.
- Priority: a taken JMP/BRZ overrides loop-back in the same cycle; loop registers are unchanged in that case.
- loop_err:
  - Set when a LOOP has end < pc_in+1; that LOOP is then treated as NOP.
  - Set when a LOOP decodes while the loop stack is full.
  - Cleared only by rst.
- Address arithmetic is modulo 2^ADDR_W. A LOOP at address 0xFFFF therefore has start 0x0000.
- LOOP itself is forwarded to execute as-is; execute treats it as NOP.
- Reset mid-loop aborts the loop immediately; fetch restarts at address 0.

Optional Feature:
DSP_DECODE_NEST_EN
- Defined:
  - Loop state is a 2-entry stack.
  - A LOOP in ACTIVE pushes a new level; the inner level is checked first for loop-back.
  - When the inner level exhausts, it pops and the outer level resumes.
  - A LOOP with both entries in use sets loop_err and is ignored.
  - If the inner and outer end addresses coincide, the inner level takes priority; the outer level is evaluated on its next arrival at end.
- Not defined:
  - Single level only.
  - Any LOOP in ACTIVE sets loop_err and is treated as NOP.

Test Plan:
- Release rst, stream NOPs at pc 0..3 → valid_out rises 1 cycle after the first edge; jump_flag stays 0; all other outputs stay 0 until the first NOP registers.
- JMP imm = 0x0040 at pc 5 → jump_flag = 1 and jump_addr = 0x0040 in the same cycle; op_out = 0x30 one cycle later.
- BRZ imm = 0x0010 at pc 7: zero_flag = 0 → no jump; zero_flag = 1 → jump_addr = 0x0010.
- LOOP N = 3, end = 0x0012 at pc 0x0010 → body 0x11..0x12 executes 3 times; jump_addr = 0x0011 at the first two visits to 0x12; loop_active falls after the third.
- LOOP with end = 0x0005 at pc 0x0008 → loop_err = 1, no loop; assert rst mid-loop → loop_active and loop_err are 0 immediately.
- Nested LOOP inside an active loop: with DSP_DECODE_NEST_EN → inner 2 × outer 2 gives 4 inner-body passes; without it → loop_err = 1 and the outer loop completes normally.

Source files
------------

// File: rtl/dsp_decode.sv
// Decode stage: same-cycle JMP/BRZ/zero-overhead LOOP redirect to fetch, registered fields to execute.
// Define DSP_DECODE_NEST_EN for a 2-level loop stack; the default build supports a single loop level.
module dsp_decode #(
  parameter int INST_W = 32,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] instruction_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              zero_flag,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              jump_flag,
  output logic [5:0]        op_out,
  output logic [3:0]        rd_out,
  output logic [3:0]        rs_out,
  output logic [15:0]       imm_out,
  output logic              valid_out,
  output logic              loop_active,
  output logic              loop_err
);

  localparam logic [5:0] OP_JMP  = 6'h30;
  localparam logic [5:0] OP_BRZ  = 6'h31;
  localparam logic [5:0] OP_LOOP = 6'h32;

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;

  logic [5:0]        op_p0;
  logic [15:0]       imm_p0;
  logic [CNT_W-1:0]  cnt_p0;
  logic [ADDR_W-1:0] end_p0, pc_nxt_p0;
  logic              loop_ok_p0, br_taken_p0;

  logic [ADDR_W-1:0] lp_start, lp_start_nxt, lp_end, lp_end_nxt;
  logic [CNT_W-1:0]  lp_cnt, lp_cnt_nxt;
  logic              err_set, jflag_c;
  logic [ADDR_W-1:0] jaddr_c;

`ifdef DSP_DECODE_NEST_EN
  logic [ADDR_W-1:0] in_start, in_start_nxt, in_end, in_end_nxt;
  logic [CNT_W-1:0]  in_cnt, in_cnt_nxt;
  logic              in_vld, in_vld_nxt;
`endif

  // ---- p0: combinational decode and control-flow resolution ----
  always_comb begin
    op_p0       = instruction_in[31:26];
    imm_p0      = instruction_in[15:0];
    end_p0      = ADDR_W'(instruction_in[15:0]);
    cnt_p0      = CNT_W'(instruction_in[25:16]);
    if (cnt_p0 == '0) cnt_p0 = CNT_W'(1);
    pc_nxt_p0   = pc_in + ADDR_W'(1);
    loop_ok_p0  = (end_p0 >= pc_nxt_p0);
    br_taken_p0 = (op_p0 == OP_JMP) || ((op_p0 == OP_BRZ) && zero_flag);

    state_nxt    = state;
    lp_start_nxt = lp_start;
    lp_end_nxt   = lp_end;
    lp_cnt_nxt   = lp_cnt;
    err_set      = 1'b0;
    jflag_c      = 1'b0;
    jaddr_c      = ADDR_W'(imm_p0);
`ifdef DSP_DECODE_NEST_EN
    in_start_nxt = in_start;
    in_end_nxt   = in_end;
    in_cnt_nxt   = in_cnt;
    in_vld_nxt   = in_vld;
`endif

    if (br_taken_p0) begin
      jflag_c = 1'b1;
`ifdef DSP_DECODE_NEST_EN
    end else if (in_vld && (pc_in == in_end)) begin
      // Inner level owns a shared end address; the outer level waits for its next arrival.
      if (in_cnt > CNT_W'(1)) begin
        jflag_c    = 1'b1;
        jaddr_c    = in_start;
        in_cnt_nxt = in_cnt - CNT_W'(1);
      end else begin
        in_vld_nxt = 1'b0;
      end
`endif
    end else if ((state == ACTIVE) && (pc_in == lp_end)) begin
      if (lp_cnt > CNT_W'(1)) begin
        jflag_c    = 1'b1;
        jaddr_c    = lp_start;
        lp_cnt_nxt = lp_cnt - CNT_W'(1);
      end else begin
        state_nxt = IDLE;
`ifdef DSP_DECODE_NEST_EN
        in_vld_nxt = 1'b0;
`endif
      end
    end else if (op_p0 == OP_LOOP) begin
`ifdef DSP_DECODE_NEST_EN
      if (!loop_ok_p0 || in_vld) begin
        err_set = 1'b1;
      end else if (state == IDLE) begin
        lp_start_nxt = pc_nxt_p0;
        lp_end_nxt   = end_p0;
        lp_cnt_nxt   = cnt_p0;
        state_nxt    = ACTIVE;
      end else begin
        in_start_nxt = pc_nxt_p0;
        in_end_nxt   = end_p0;
        in_cnt_nxt   = cnt_p0;
        in_vld_nxt   = 1'b1;
      end
`else
      if (!loop_ok_p0 || (state == ACTIVE)) begin
        err_set = 1'b1;
      end else begin
        lp_start_nxt = pc_nxt_p0;
        lp_end_nxt   = end_p0;
        lp_cnt_nxt   = cnt_p0;
        state_nxt    = ACTIVE;
      end
`endif
    end
  end

  assign jump_flag   = jflag_c & ~rst;
  assign jump_addr   = jaddr_c;
  assign loop_active = (state == ACTIVE);

  // ---- p1: registered fields and loop state ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lp_start  <= '0;
      lp_end    <= '0;
      lp_cnt    <= '0;
      loop_err  <= 1'b0;
      valid_out <= 1'b0;
      op_out    <= '0;
      rd_out    <= '0;
      rs_out    <= '0;
      imm_out   <= '0;
    end else begin
      state     <= state_nxt;
      lp_start  <= lp_start_nxt;
      lp_end    <= lp_end_nxt;
      lp_cnt    <= lp_cnt_nxt;
      loop_err  <= loop_err | err_set;
      valid_out <= 1'b1;
      op_out    <= op_p0;
      rd_out    <= instruction_in[25:22];
      rs_out    <= instruction_in[21:18];
      imm_out   <= imm_p0;
    end
  end

`ifdef DSP_DECODE_NEST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_start <= '0;
      in_end   <= '0;
      in_cnt   <= '0;
      in_vld   <= 1'b0;
    end else begin
      in_start <= in_start_nxt;
      in_end   <= in_end_nxt;
      in_cnt   <= in_cnt_nxt;
      in_vld   <= in_vld_nxt;
    end
  end
`endif

endmodule
